// File: rtl/lcd_capture_rgb565.sv
// Captures one RGB565 frame from a parallel LCD-style sync/pixel bus into a frame RAM.
// Sync and pixel inputs are registered on each pixel tick; edges are found between consecutive ticks.
module lcd_capture_rgb565 #(
  parameter int H_ACTIVE = 480,
  parameter int V_ACTIVE = 272,
  parameter int H_SKIP   = 2,
  parameter int V_SKIP   = 2
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iEnClk,
  input  logic        iCapEn,
  input  logic        iHSync,
  input  logic        iVSync,
  input  logic [4:0]  iR,
  input  logic [5:0]  iG,
  input  logic [4:0]  iB,
  output logic        oRamWrEn,
  output logic [16:0] oRamWrAddr,
  output logic [15:0] oRamWrData,
  output logic        oBusy,
  output logic        oFrameDone,
  output logic        oLineErr,
  output logic        oFrameErr
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAITV  = 2'd1;
  localparam logic [1:0] S_SKIPV  = 2'd2;
  localparam logic [1:0] S_ACTIVE = 2'd3;

  localparam logic [15:0] H_FIRST = 16'(H_SKIP);
  localparam logic [15:0] H_END   = 16'(H_SKIP + H_ACTIVE);
  localparam logic [15:0] H_LAST  = 16'(H_ACTIVE - 1);
  localparam logic [15:0] V_LAST  = 16'(V_ACTIVE - 1);
  localparam logic [15:0] V_SKIPS = 16'(V_SKIP);
  localparam logic [16:0] H_STEP  = 17'(H_ACTIVE);

  logic [1:0]  state;
  logic        hs_q, vs_q, hs_prev, vs_prev;
  logic [1:0]  warm;
  logic [15:0] pix_q;
  logic [15:0] hcnt;
  logic        line_open;
  logic [15:0] line_idx;
  logic [16:0] line_base;
  logic [15:0] vskip_cnt;
  logic        done_pend;

  logic        edges_ok, hs_rise, hs_fall, vs_rise, vs_fall;
  logic [15:0] idx, col;
  logic        in_window, last_px;
  logic [1:0]  exit_state;

  // Edges only count once both history registers hold real samples taken after reset,
  // so a sync that was already high when reset released never looks like a fresh edge.
  assign edges_ok   = warm[1];
  assign hs_rise    = edges_ok &  hs_q & ~hs_prev;
  assign hs_fall    = edges_ok & ~hs_q &  hs_prev;
  assign vs_rise    = edges_ok &  vs_q & ~vs_prev;
  assign vs_fall    = edges_ok & ~vs_q &  vs_prev;

  assign idx        = hs_rise ? 16'd0 : hcnt;
  assign col        = idx - H_FIRST;
  assign in_window  = (idx >= H_FIRST) && (idx < H_END);
  assign last_px    = (col == H_LAST) && (line_idx == V_LAST);
  assign exit_state = iCapEn ? S_WAITV : S_IDLE;
  assign oBusy      = (state == S_SKIPV) || (state == S_ACTIVE);

  // Input stage, capture FSM and write port all advance on pixel ticks; the two strobes self-clear every clock.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state      <= S_IDLE;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      hs_prev    <= 1'b0;
      vs_prev    <= 1'b0;
      warm       <= 2'b00;
      pix_q      <= 16'd0;
      hcnt       <= 16'd0;
      line_open  <= 1'b0;
      line_idx   <= 16'd0;
      line_base  <= 17'd0;
      vskip_cnt  <= 16'd0;
      done_pend  <= 1'b0;
      oRamWrEn   <= 1'b0;
      oRamWrAddr <= 17'd0;
      oRamWrData <= 16'd0;
      oFrameDone <= 1'b0;
      oLineErr   <= 1'b0;
      oFrameErr  <= 1'b0;
    end else begin
      oRamWrEn   <= 1'b0;
      done_pend  <= 1'b0;
      oFrameDone <= done_pend;
      if (iEnClk) begin
        hs_q    <= iHSync;
        vs_q    <= iVSync;
        hs_prev <= hs_q;
        vs_prev <= vs_q;
        pix_q   <= {iR, iG, iB};
        warm    <= {warm[0], 1'b1};
        case (state)
          S_IDLE: begin
            if (iCapEn) begin
              state     <= S_WAITV;
              oLineErr  <= 1'b0;
              oFrameErr <= 1'b0;
            end
          end
          S_WAITV: begin
            if (!iCapEn) begin
              state <= S_IDLE;
            end else if (vs_rise) begin
              state     <= S_SKIPV;
              vskip_cnt <= 16'd0;
              line_idx  <= 16'd0;
              line_base <= 17'd0;
              line_open <= 1'b0;
              hcnt      <= 16'd0;
            end
          end
          S_SKIPV: begin
            if (vs_fall) begin
              oFrameErr <= 1'b1;
              state     <= exit_state;
            end else if (vskip_cnt == V_SKIPS) begin
              state <= S_ACTIVE;
            end else if (hs_fall) begin
              vskip_cnt <= vskip_cnt + 16'd1;
            end
          end
          default: begin
            if (vs_fall) begin
              oFrameErr <= 1'b1;
              state     <= exit_state;
            end else if (hs_q && (hs_rise || line_open)) begin
              line_open <= 1'b1;
              hcnt      <= (idx == H_END) ? idx : idx + 16'd1;
              if (in_window) begin
                oRamWrEn   <= 1'b1;
                oRamWrAddr <= line_base + {1'b0, col};
                oRamWrData <= pix_q;
                if (last_px) begin
                  done_pend <= 1'b1;
                  state     <= exit_state;
                end
              end
            end else if (!hs_q && line_open) begin
              // A short line still consumes its whole address slot so later lines stay aligned.
              line_open <= 1'b0;
              if (hcnt < H_END) oLineErr <= 1'b1;
              line_base <= line_base + H_STEP;
              line_idx  <= line_idx + 16'd1;
              if (line_idx == V_LAST) begin
                done_pend <= 1'b1;
                state     <= exit_state;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_capture_rgb565.sv
// Directed bench for lcd_capture_rgb565: a frame generator predicts every RAM write and
// frame-done pulse from the capture rules, and a per-cycle checker compares against them.
module tb_lcd_capture_rgb565;

  localparam int H_ACTIVE = 480;
  localparam int V_ACTIVE = 6;
  localparam int H_SKIP   = 2;
  localparam int V_SKIP   = 2;

  logic        iClk = 1'b0;
  logic        iRst, iEnClk, iCapEn, iHSync, iVSync;
  logic [4:0]  iR, iB;
  logic [5:0]  iG;
  logic        oRamWrEn, oBusy, oFrameDone, oLineErr, oFrameErr;
  logic [16:0] oRamWrAddr;
  logic [15:0] oRamWrData;

  lcd_capture_rgb565 #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_SKIP(H_SKIP), .V_SKIP(V_SKIP)) dut (
    .iClk(iClk), .iRst(iRst), .iEnClk(iEnClk), .iCapEn(iCapEn),
    .iHSync(iHSync), .iVSync(iVSync), .iR(iR), .iG(iG), .iB(iB),
    .oRamWrEn(oRamWrEn), .oRamWrAddr(oRamWrAddr), .oRamWrData(oRamWrData),
    .oBusy(oBusy), .oFrameDone(oFrameDone), .oLineErr(oLineErr), .oFrameErr(oFrameErr)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    int          due;
    logic [16:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  done_q[$];
  int  pc = 0;
  int  n_checks = 0;
  int  n_fail = 0;

  int          wr_count, done_count, gap_hits, first_pc, px0_pc;
  logic [16:0] first_addr, last_addr;
  logic [15:0] first_data;
  bit          saw_1920;

  int cfg_lines, cfg_short_line, cfg_short_len, cfg_period;
  int cfg_cap_on_line, cfg_cap_off_line, cfg_rst_line;
  bit cfg_expect, cfg_pin;

  always @(posedge iClk) pc <= pc + 1;

  function automatic void check_output(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Per-cycle comparison of the write port and frame-done strobe against the predicted queues.
  always @(negedge iClk) begin
    wr_t e;
    if (!iRst) begin
      if (oRamWrEn) begin
        if (wr_count == 0) begin
          first_addr = oRamWrAddr;
          first_data = oRamWrData;
          first_pc   = pc;
        end
        wr_count++;
        last_addr = oRamWrAddr;
        if (oRamWrAddr >= 17'd1540 && oRamWrAddr <= 17'd1919) gap_hits++;
        if (oRamWrAddr == 17'd1920) saw_1920 = 1'b1;
        if (exp_q.size() == 0 || exp_q[0].due != pc) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_write: got addr %0d data %0h at cycle %0d, expected no write", oRamWrAddr, oRamWrData, pc);
        end else begin
          e = exp_q.pop_front();
          check_output("write_addr_data", {oRamWrAddr, oRamWrData}, {e.addr, e.data});
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= pc) begin
        e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("[TB] FAIL missing_write: got no strobe at cycle %0d, expected addr %0d", pc, e.addr);
      end
      if (oFrameDone) begin
        done_count++;
        n_checks++;
        if (done_q.size() > 0 && done_q[0] == pc) begin
          void'(done_q.pop_front());
        end else begin
          n_fail++;
          $display("[TB] FAIL unexpected_frame_done: got pulse at cycle %0d, expected none", pc);
        end
      end else if (done_q.size() > 0 && done_q[0] <= pc) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL missing_frame_done: got 0 at cycle %0d, expected pulse at %0d", pc, done_q[0]);
        void'(done_q.pop_front());
      end
    end
  end

  task automatic drive_tick(input logic hs, input logic vs, input logic [4:0] r,
                            input logic [5:0] g, input logic [4:0] b, output int tick_pc);
    @(negedge iClk);
    iHSync = hs; iVSync = vs; iR = r; iG = g; iB = b;
    iEnClk = 1'b1;
    tick_pc = pc + 1;
    for (int i = 1; i < cfg_period; i++) begin
      @(negedge iClk);
      iEnClk = 1'b0;
    end
  endtask

  task automatic idle_ticks(input int n);
    int tp;
    for (int i = 0; i < n; i++) drive_tick(1'b0, 1'b0, 5'd0, 6'd0, 5'd0, tp);
    @(negedge iClk);
    iEnClk = 1'b0;
    repeat (2) @(negedge iClk);
  endtask

  task automatic do_reset();
    @(posedge iClk);
    #2;
    iRst = 1'b1;
    #1;
    check_output("async_reset_outputs",
                 {oRamWrEn, oRamWrAddr, oRamWrData, oBusy, oFrameDone, oLineErr, oFrameErr}, 64'd0);
    exp_q.delete();
    done_q.delete();
    @(negedge iClk);
    iEnClk = 1'b0;
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
  endtask

  task automatic clear_stats();
    wr_count = 0; done_count = 0; gap_hits = 0; saw_1920 = 1'b0;
    first_pc = 0; px0_pc = 0;
  endtask

  // One frame: blanking, vsync rise, skip lines, data lines, vsync fall; pushes expected writes.
  task automatic apply_stimulus();
    int tp, len, col;
    bit expect_now;
    logic [4:0] r, b;
    logic [5:0] g;
    wr_t w;
    expect_now = cfg_expect;
    repeat (2) drive_tick(1'b0, 1'b0, 5'd0, 6'd0, 5'd0, tp);
    repeat (2) drive_tick(1'b0, 1'b1, 5'd0, 6'd0, 5'd0, tp);
    for (int s = 0; s < V_SKIP; s++) begin
      repeat (4) drive_tick(1'b1, 1'b1, 5'($urandom), 6'($urandom), 5'($urandom), tp);
      repeat (2) drive_tick(1'b0, 1'b1, 5'd0, 6'd0, 5'd0, tp);
    end
    for (int l = 0; l < cfg_lines; l++) begin
      if (l == cfg_cap_on_line)  iCapEn = 1'b1;
      if (l == cfg_cap_off_line) iCapEn = 1'b0;
      if (l == 1 && expect_now) check_output("busy_mid_frame", oBusy, 1);
      if (l == cfg_short_line) len = H_SKIP + cfg_short_len;
      else if (l == 1)         len = H_SKIP + H_ACTIVE + 3;
      else                     len = H_SKIP + H_ACTIVE;
      for (int t = 0; t < len; t++) begin
        if (l == cfg_rst_line && t == 100 && expect_now) begin
          do_reset();
          expect_now = 1'b0;
        end
        r = 5'($urandom); g = 6'($urandom); b = 5'($urandom);
        if (cfg_pin && l == 0 && t == H_SKIP) begin
          r = 5'h1F; g = 6'h00; b = 5'h0A;
        end
        drive_tick(1'b1, 1'b1, r, g, b, tp);
        if (l == 0 && t == H_SKIP) px0_pc = tp;
        col = t - H_SKIP;
        if (expect_now && col >= 0 && col < H_ACTIVE && l < V_ACTIVE) begin
          w.due  = tp + cfg_period;
          w.addr = 17'(l * H_ACTIVE + col);
          w.data = {r, g, b};
          exp_q.push_back(w);
          if (l == V_ACTIVE - 1 && col == H_ACTIVE - 1) done_q.push_back(w.due + 1);
        end
      end
      repeat (2) drive_tick(1'b0, 1'b1, 5'd0, 6'd0, 5'd0, tp);
    end
    repeat (3) drive_tick(1'b0, 1'b0, 5'd0, 6'd0, 5'd0, tp);
    @(negedge iClk);
    iEnClk = 1'b0;
    repeat (4) @(negedge iClk);
    check_output("queues_drained", exp_q.size() + done_q.size(), 0);
  endtask

  task automatic set_cfg(input int lines, input bit expct, input int period);
    cfg_lines = lines; cfg_expect = expct; cfg_period = period;
    cfg_short_line = -1; cfg_short_len = 0; cfg_pin = 1'b0;
    cfg_cap_on_line = -1; cfg_cap_off_line = -1; cfg_rst_line = -1;
    clear_stats();
  endtask

  initial begin
    iRst = 1'b1; iEnClk = 1'b0; iCapEn = 1'b0; iHSync = 1'b0; iVSync = 1'b0;
    iR = 5'd0; iG = 6'd0; iB = 5'd0;
    cfg_period = 1;
    clear_stats();
    repeat (3) @(negedge iClk);
    check_output("reset_state",
                 {oRamWrEn, oRamWrAddr, oRamWrData, oBusy, oFrameDone, oLineErr, oFrameErr}, 64'd0);
    iRst = 1'b0;

    $display("[TB] full frame, tick every 2nd cycle");
    iCapEn = 1'b1;
    set_cfg(V_ACTIVE, 1'b1, 2);
    cfg_pin = 1'b1;
    apply_stimulus();
    check_output("f1_write_count", wr_count, V_ACTIVE * H_ACTIVE);
    check_output("f1_first_addr", first_addr, 0);
    check_output("f1_first_data", first_data, 16'hF80A);
    check_output("f1_first_latency", first_pc - px0_pc, 2);
    check_output("f1_last_addr", last_addr, V_ACTIVE * H_ACTIVE - 1);
    check_output("f1_done_count", done_count, 1);
    check_output("f1_busy_after", oBusy, 0);
    check_output("f1_errors", {oLineErr, oFrameErr}, 2'b00);

    $display("[TB] short line 3");
    set_cfg(V_ACTIVE, 1'b1, 1);
    cfg_short_line = 3; cfg_short_len = 100;
    apply_stimulus();
    check_output("f2_write_count", wr_count, (V_ACTIVE - 1) * H_ACTIVE + 100);
    check_output("f2_gap_writes", gap_hits, 0);
    check_output("f2_addr1920_written", saw_1920, 1);
    check_output("f2_errors", {oLineErr, oFrameErr}, 2'b10);
    check_output("f2_done_count", done_count, 1);

    $display("[TB] vsync falls after 3 lines");
    set_cfg(3, 1'b1, 1);
    apply_stimulus();
    check_output("f3_write_count", wr_count, 3 * H_ACTIVE);
    check_output("f3_done_count", done_count, 0);
    check_output("f3_errors", {oLineErr, oFrameErr}, 2'b11);

    $display("[TB] full frame after short frame, then re-arm");
    set_cfg(V_ACTIVE, 1'b1, 1);
    apply_stimulus();
    check_output("f4_write_count", wr_count, V_ACTIVE * H_ACTIVE);
    check_output("f4_first_addr", first_addr, 0);
    check_output("f4_errors_sticky", {oLineErr, oFrameErr}, 2'b11);
    iCapEn = 1'b0;
    idle_ticks(3);
    check_output("disarm_busy", oBusy, 0);
    iCapEn = 1'b1;
    idle_ticks(3);
    check_output("rearm_errors_cleared", {oLineErr, oFrameErr}, 2'b00);
    iCapEn = 1'b0;
    idle_ticks(3);

    $display("[TB] capture armed mid-frame");
    set_cfg(V_ACTIVE, 1'b0, 1);
    cfg_cap_on_line = 2;
    apply_stimulus();
    check_output("f5_write_count", wr_count, 0);
    set_cfg(V_ACTIVE, 1'b1, 1);
    apply_stimulus();
    check_output("f6_write_count", wr_count, V_ACTIVE * H_ACTIVE);
    check_output("f6_done_count", done_count, 1);

    $display("[TB] capture disarmed mid-frame");
    set_cfg(V_ACTIVE, 1'b1, 1);
    cfg_cap_off_line = 2;
    apply_stimulus();
    check_output("f7_write_count", wr_count, V_ACTIVE * H_ACTIVE);
    check_output("f7_done_count", done_count, 1);
    check_output("f7_busy_after", oBusy, 0);
    set_cfg(V_ACTIVE, 1'b0, 1);
    apply_stimulus();
    check_output("f8_write_count", wr_count, 0);

    $display("[TB] reset during line 3");
    iCapEn = 1'b1;
    set_cfg(V_ACTIVE, 1'b1, 1);
    cfg_rst_line = 3;
    apply_stimulus();
    check_output("f9_done_count", done_count, 0);
    check_output("f9_errors", {oLineErr, oFrameErr, oBusy}, 3'b000);
    set_cfg(V_ACTIVE, 1'b1, 1);
    apply_stimulus();
    check_output("f10_write_count", wr_count, V_ACTIVE * H_ACTIVE);
    check_output("f10_first_addr", first_addr, 0);
    check_output("f10_done_count", done_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
